// File: rtl/pp_hdr_extract_if.sv
// AXI-Stream bundle shared by the inbound and payload sides of pp_hdr_extract.
interface pp_hdr_extract_if #(
  parameter int unsigned TDATA_WIDTH = 128,
  parameter int unsigned TUSER_WIDTH = 4
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic                     tlast;
  logic [TDATA_WIDTH/8-1:0] tstrb;
  logic [TUSER_WIDTH-1:0]   tuser;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, tlast, tstrb, tuser, tvalid, input tready);
  modport slave  (input tdata, tlast, tstrb, tuser, tvalid, output tready);
endinterface

// File: rtl/pp_hdr_extract.sv
// Header extractor: strips the first bead of each packet onto a header
// channel, forwards the remaining beads, drops errored packets, counts both.
module pp_hdr_extract #(
  parameter int unsigned TDATA_WIDTH = 128,
  parameter int unsigned TUSER_WIDTH = 4,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  pp_hdr_extract_if.slave      s,
  pp_hdr_extract_if.master     m,
  output logic [47:0]          hdr_dst,
  output logic [47:0]          hdr_src,
  output logic [15:0]          hdr_type,
  output logic [15:0]          hdr_len,
  output logic                 hdr_no_pay,
  output logic                 hdr_valid,
  input  logic                 hdr_ready,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic [1:0] {S_HDR, S_PAY, S_DROP} state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_s_tready;
  logic   w_acc;
  logic   w_hdr_load;
  logic   w_drop;
  logic   w_pay_load;
  logic   w_pkt_inc;

  logic                     r_hdr_valid;
  logic [47:0]              r_hdr_dst;
  logic [47:0]              r_hdr_src;
  logic [15:0]              r_hdr_type;
  logic [15:0]              r_hdr_len;
  logic                     r_hdr_no_pay;

  logic                     r_m_tvalid;
  logic [TDATA_WIDTH-1:0]   r_m_tdata;
  logic                     r_m_tlast;
  logic [TDATA_WIDTH/8-1:0] r_m_tstrb;
  logic [TUSER_WIDTH-1:0]   r_m_tuser;

  logic [CNT_WIDTH-1:0]     r_pkt_cnt;
  logic [CNT_WIDTH-1:0]     r_drop_cnt;

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_HDR;
    else      r_state <= w_state_nxt;
  end

  // Ready per state, acceptance, next state and per-bead actions.
  always_comb begin
    w_state_nxt = r_state;
    w_s_tready  = 1'b0;
    w_acc       = 1'b0;
    w_hdr_load  = 1'b0;
    w_drop      = 1'b0;
    w_pay_load  = 1'b0;
    w_pkt_inc   = 1'b0;
    case (r_state)
      S_HDR:   w_s_tready = !r_hdr_valid || hdr_ready;
      S_PAY:   w_s_tready = !r_m_tvalid || m.tready;
      S_DROP:  w_s_tready = 1'b1;
      default: w_s_tready = 1'b0;
    endcase
    if (!rst) w_s_tready = 1'b0;
    w_acc = s.tvalid && w_s_tready;
    if (w_acc) begin
      case (r_state)
        S_HDR: begin
          if (s.tuser[0]) begin
            w_drop = 1'b1;
            if (!s.tlast) w_state_nxt = S_DROP;
          end else begin
            w_hdr_load = 1'b1;
            if (s.tlast) w_pkt_inc   = 1'b1;
            else         w_state_nxt = S_PAY;
          end
        end
        S_PAY: begin
          w_pay_load = 1'b1;
          if (s.tlast) begin
            w_pkt_inc   = 1'b1;
            w_state_nxt = S_HDR;
          end
        end
        S_DROP: begin
          if (s.tlast) w_state_nxt = S_HDR;
        end
        default: w_state_nxt = S_HDR;
      endcase
    end
  end

  // Header channel register; a new header on the consuming edge reloads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hdr_valid  <= 1'b0;
      r_hdr_dst    <= '0;
      r_hdr_src    <= '0;
      r_hdr_type   <= '0;
      r_hdr_len    <= '0;
      r_hdr_no_pay <= 1'b0;
    end else if (w_hdr_load) begin
      r_hdr_valid  <= 1'b1;
      r_hdr_dst    <= s.tdata[47:0];
      r_hdr_src    <= s.tdata[95:48];
      r_hdr_type   <= s.tdata[111:96];
      r_hdr_len    <= s.tdata[127:112];
      r_hdr_no_pay <= s.tlast;
    end else if (r_hdr_valid && hdr_ready) begin
      r_hdr_valid  <= 1'b0;
    end
  end

  // Payload output register; a new bead on the consuming edge reloads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tstrb  <= '0;
      r_m_tuser  <= '0;
    end else if (w_pay_load) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= s.tdata;
      r_m_tlast  <= s.tlast;
      r_m_tstrb  <= s.tstrb;
      r_m_tuser  <= s.tuser;
    end else if (r_m_tvalid && m.tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  // Statistics counters, wrapping at their width.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_pkt_inc) r_pkt_cnt  <= r_pkt_cnt + CNT_WIDTH'(1);
      if (w_drop)    r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
    end
  end

  assign s.tready   = w_s_tready;
  assign m.tvalid   = r_m_tvalid;
  assign m.tdata    = r_m_tdata;
  assign m.tlast    = r_m_tlast;
  assign m.tstrb    = r_m_tstrb;
  assign m.tuser    = r_m_tuser;
  assign hdr_valid  = r_hdr_valid;
  assign hdr_dst    = r_hdr_dst;
  assign hdr_src    = r_hdr_src;
  assign hdr_type   = r_hdr_type;
  assign hdr_len    = r_hdr_len;
  assign hdr_no_pay = r_hdr_no_pay;
  assign pkt_cnt    = r_pkt_cnt;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_pp_hdr_extract.sv
// Self-checking bench for pp_hdr_extract: reset, table of header decodes,
// directed multi-cycle sequences and a randomized packet-level model.
module tb_pp_hdr_extract;
  localparam int unsigned DW = 128;
  localparam int unsigned UW = 4;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [47:0]   hdr_dst, hdr_src;
  logic [15:0]   hdr_type, hdr_len;
  logic          hdr_no_pay, hdr_valid;
  logic          hdr_ready = 1'b1;
  logic [CW-1:0] pkt_cnt, drop_cnt;

  pp_hdr_extract_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) s_if ();
  pp_hdr_extract_if #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW)) m_if ();

  pp_hdr_extract #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s(s_if.slave), .m(m_if.master),
    .hdr_dst(hdr_dst), .hdr_src(hdr_src), .hdr_type(hdr_type), .hdr_len(hdr_len),
    .hdr_no_pay(hdr_no_pay), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_err    = 0;
  int unsigned w;

  typedef struct {
    logic [127:0] data;
    logic         last;
    logic         err;
    logic [47:0]  dst;
    logic [47:0]  src;
    logic [15:0]  typ;
    logic [15:0]  len;
    logic         hv;
  } vec_t;

  vec_t         tbl[4];
  logic [159:0] exp_hdr_q[$];
  logic [159:0] exp_pay_q[$];
  logic [148:0] stim_q[$];
  int unsigned  exp_pkt, exp_drop;

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_to(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic logic [159:0] hdr_now();
    return {31'd0, hdr_dst, hdr_src, hdr_type, hdr_len, hdr_no_pay};
  endfunction

  function automatic logic [159:0] pay_now();
    return {11'd0, m_if.tdata, m_if.tlast, m_if.tstrb, m_if.tuser};
  endfunction

  // Reference header record from the field layout of the header bead.
  function automatic logic [159:0] hdr_model(input logic [127:0] d, input logic np);
    return {31'd0, d[47:0], d[95:48], d[111:96], d[127:112], np};
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    s_if.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Present one bead and hold it until accepted; returns cycles waited.
  task automatic send(input logic [127:0] d, input logic l, input logic [15:0] st,
                      input logic [3:0] u, output int unsigned waits);
    waits = 0;
    s_if.tdata = d; s_if.tlast = l; s_if.tstrb = st; s_if.tuser = u;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    while (!s_if.tready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!s_if.tready) fail_to("send");
    @(posedge clk);
    #1 s_if.tvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] h;
    tbl[0] = '{data:128'h0010_0800_AABBCCDDEEFF_112233445566, last:1'b1, err:1'b0,
               dst:48'h112233445566, src:48'hAABBCCDDEEFF, typ:16'h0800, len:16'h0010, hv:1'b1};
    tbl[1] = '{data:128'hFFFF_0000_000000000000_FFFFFFFFFFFF, last:1'b1, err:1'b0,
               dst:48'hFFFFFFFFFFFF, src:48'h0, typ:16'h0000, len:16'hFFFF, hv:1'b1};
    tbl[2] = '{data:128'h1234_5678_9ABCDEF01234_56789ABCDEF0, last:1'b1, err:1'b1,
               dst:48'h0, src:48'h0, typ:16'h0, len:16'h0, hv:1'b0};
    tbl[3] = '{data:128'h0001_86DD_0123456789AB_CDEF01234567, last:1'b1, err:1'b0,
               dst:48'hCDEF01234567, src:48'h0123456789AB, typ:16'h86DD, len:16'h0001, hv:1'b1};

    m_if.tready = 1'b1;
    s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tstrb = '0; s_if.tuser = '0; s_if.tvalid = 1'b0;

    // Reset with tvalid asserted, then first bead decoded as a header.
    h = 128'h0040_0806_010203040506_0A0B0C0D0E0F;
    s_if.tdata = h; s_if.tlast = 1'b1; s_if.tuser = '0; s_if.tvalid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", s_if.tready, 0);
    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_hdr_valid", hdr_valid, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_hdr_fields", hdr_now(), 0);
    chk("rst_m_fields", pay_now(), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    send(h, 1'b1, 16'hFFFF, 4'h0, w);
    chk("post_rst_wait", w, 0);
    chk("post_rst_hdr_valid", hdr_valid, 1);
    chk("post_rst_hdr", hdr_now(), {31'd0, 48'h0A0B0C0D0E0F, 48'h010203040506, 16'h0806, 16'h0040, 1'b1});
    chk("post_rst_pkt_cnt", pkt_cnt, 1);

    // Reset mid-packet: next bead after reset is a header, not payload.
    send(128'h0002_0800_111111111111_222222222222, 1'b0, 16'hFFFF, 4'h0, w);
    do_reset();
    send(128'h0003_0801_333333333333_444444444444, 1'b1, 16'hFFFF, 4'h0, w);
    chk("midrst_hdr", hdr_now(), {31'd0, 48'h444444444444, 48'h333333333333, 16'h0801, 16'h0003, 1'b1});
    chk("midrst_m_tvalid", m_if.tvalid, 0);

    // Table of header-only packets.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(tbl[i].data, tbl[i].last, 16'hFFFF, {3'b000, tbl[i].err}, w);
      chk("tbl_hdr_valid", hdr_valid, tbl[i].hv);
      if (tbl[i].hv)
        chk("tbl_fields", hdr_now(), {31'd0, tbl[i].dst, tbl[i].src, tbl[i].typ, tbl[i].len, tbl[i].last});
    end
    chk("tbl_pkt_cnt", pkt_cnt, 3);
    chk("tbl_drop_cnt", drop_cnt, 1);

    // Three-bead packet with both consumers ready.
    do_reset();
    send(128'h0010_0800_AABBCCDDEEFF_112233445566, 1'b0, 16'h0000, 4'h0, w);
    chk("p3_hdr", hdr_now(), {31'd0, 48'h112233445566, 48'hAABBCCDDEEFF, 16'h0800, 16'h0010, 1'b0});
    chk("p3_hdr_valid", hdr_valid, 1);
    chk("p3_no_m_yet", m_if.tvalid, 0);
    send(128'hB2, 1'b0, 16'h0F0F, 4'h6, w);
    chk("p3_b2", {m_if.tvalid, pay_now()}, {1'b1, 11'd0, 128'hB2, 1'b0, 16'h0F0F, 4'h6});
    chk("p3_hdr_taken", hdr_valid, 0);
    send(128'hB3, 1'b1, 16'h00FF, 4'h1, w);
    chk("p3_b3", {m_if.tvalid, pay_now()}, {1'b1, 11'd0, 128'hB3, 1'b1, 16'h00FF, 4'h1});
    chk("p3_pkt_cnt", pkt_cnt, 1);
    @(posedge clk); #1;
    chk("p3_m_idle", m_if.tvalid, 0);

    // Errored four-bead packet is consumed silently.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(128'hE0 + 128'(i), i == 3, 16'hFFFF, (i == 0) ? 4'h1 : 4'h0, w);
      chk("drop_no_wait", w, 0);
      chk("drop_no_out", {hdr_valid, m_if.tvalid}, 0);
    end
    chk("drop_cnt", drop_cnt, 1);
    chk("drop_pkt_cnt", pkt_cnt, 0);
    send(128'h5, 1'b1, 16'hFFFF, 4'h0, w);
    chk("drop_then_hdr", {hdr_valid, pkt_cnt}, {1'b1, 32'd1});

    // Downstream stall mid-payload.
    do_reset();
    send(128'h77, 1'b0, 16'hFFFF, 4'h0, w);
    send(128'hA1, 1'b0, 16'h00FF, 4'h2, w);
    m_if.tready = 1'b0;
    s_if.tdata = 128'hA2; s_if.tlast = 1'b0; s_if.tstrb = 16'h0FFF; s_if.tuser = 4'h3;
    s_if.tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_s_tready", s_if.tready, 0);
      chk("stall_m_hold", {m_if.tvalid, pay_now()}, {1'b1, 11'd0, 128'hA1, 1'b0, 16'h00FF, 4'h2});
      @(posedge clk); #1;
    end
    m_if.tready = 1'b1;
    send(128'hA2, 1'b0, 16'h0FFF, 4'h3, w);
    chk("stall_release_wait", w, 0);
    chk("stall_a2", {m_if.tvalid, pay_now()}, {1'b1, 11'd0, 128'hA2, 1'b0, 16'h0FFF, 4'h3});
    send(128'hA3, 1'b1, 16'hFFFF, 4'h4, w);
    chk("stall_a3", {m_if.tvalid, pay_now()}, {1'b1, 11'd0, 128'hA3, 1'b1, 16'hFFFF, 4'h4});
    @(posedge clk); #1;
    chk("stall_end", {m_if.tvalid, pkt_cnt}, {1'b0, 32'd1});

    // Back-to-back packets with the header consumer held off.
    do_reset();
    hdr_ready = 1'b0;
    send(128'h0001_0001_00000000000A_00000000000A, 1'b0, 16'hFFFF, 4'h0, w);
    send(128'hC1, 1'b1, 16'hFFFF, 4'h0, w);
    s_if.tdata = 128'h0002_0002_00000000000B_00000000000B; s_if.tlast = 1'b0; s_if.tuser = 4'h0;
    s_if.tvalid = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      chk("b2b_stall", s_if.tready, 0);
      chk("b2b_hdr_hold", {hdr_valid, hdr_dst}, {1'b1, 48'h00000000000A});
      @(posedge clk); #1;
    end
    hdr_ready = 1'b1;
    send(128'h0002_0002_00000000000B_00000000000B, 1'b0, 16'hFFFF, 4'h0, w);
    chk("b2b_reload_wait", w, 0);
    chk("b2b_second_hdr", {hdr_valid, hdr_dst}, {1'b1, 48'h00000000000B});
    send(128'hC2, 1'b1, 16'hFFFF, 4'h0, w);
    chk("b2b_pkt_cnt", pkt_cnt, 2);

    // Randomized packets against a packet-level model.
    do_reset();
    exp_pkt = 0; exp_drop = 0;
    for (int p = 0; p < 40; p++) begin
      int unsigned nb;
      logic err;
      logic [127:0] hd;
      nb  = $urandom_range(1, 5);
      err = ($urandom_range(0, 3) == 0);
      hd  = {$urandom, $urandom, $urandom, $urandom};
      stim_q.push_back({hd, nb == 1, 16'($urandom), 3'($urandom), err});
      if (err) exp_drop++;
      else begin
        exp_hdr_q.push_back(hdr_model(hd, nb == 1));
        exp_pkt++;
      end
      for (int b = 1; b < int'(nb); b++) begin
        logic [148:0] bd;
        bd = {$urandom, $urandom, $urandom, $urandom, b == int'(nb) - 1, 16'($urandom), 4'($urandom)};
        stim_q.push_back(bd);
        if (!err) exp_pay_q.push_back({11'd0, bd});
      end
    end
    fork
      begin : producer
        int unsigned pw;
        while (stim_q.size() != 0) begin
          logic [148:0] bd;
          bd = stim_q.pop_front();
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          send(bd[148:21], bd[20], bd[19:4], bd[3:0], pw);
        end
      end
      begin : hdr_consumer
        int unsigned cyc = 0;
        logic held = 1'b0;
        logic [159:0] prev = '0;
        while (exp_hdr_q.size() != 0 && cyc < 6000) begin
          @(posedge clk); #1 hdr_ready = 1'($urandom_range(0, 1));
          @(negedge clk); cyc++;
          if (held) begin
            chk("rnd_hdr_hold_valid", hdr_valid, 1);
            chk("rnd_hdr_hold_data", hdr_now(), prev);
          end
          if (hdr_valid && hdr_ready) chk("rnd_hdr", hdr_now(), exp_hdr_q.pop_front());
          held = hdr_valid && !hdr_ready;
          prev = hdr_now();
        end
        if (exp_hdr_q.size() != 0) fail_to("rnd_hdr_consumer");
        hdr_ready = 1'b1;
      end
      begin : pay_consumer
        int unsigned cyc = 0;
        logic held = 1'b0;
        logic [159:0] prev = '0;
        while (exp_pay_q.size() != 0 && cyc < 6000) begin
          @(posedge clk); #1 m_if.tready = 1'($urandom_range(0, 1));
          @(negedge clk); cyc++;
          if (held) begin
            chk("rnd_m_hold_valid", m_if.tvalid, 1);
            chk("rnd_m_hold_data", pay_now(), prev);
          end
          if (m_if.tvalid && m_if.tready) chk("rnd_pay", pay_now(), exp_pay_q.pop_front());
          held = m_if.tvalid && !m_if.tready;
          prev = pay_now();
        end
        if (exp_pay_q.size() != 0) fail_to("rnd_pay_consumer");
        m_if.tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rnd_no_extra_out", {hdr_valid, m_if.tvalid}, 0);
    chk("rnd_pkt_cnt", pkt_cnt, exp_pkt);
    chk("rnd_drop_cnt", drop_cnt, exp_drop);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/pp_hdr_extract.md
Name: pp_hdr_extract

Overview:
- Consumes the packet parser's inbound AXI-Stream: valid/ready handshake, tdata/tlast/tstrb/tuser.
- Strips the first beat of every packet as the header, decodes its fields onto a separate header channel, and forwards the remaining payload beats unchanged on a master AXI-Stream to downstream parser stages.
- Discards packets flagged errored on the header beat and counts forwarded and dropped packets.

Parameters:
- TDATA_WIDTH, 128 (pp_package value): stream data width in bits; must be ≥128.
- TUSER_WIDTH, pp_package value: sideband width; bit 0 is the error flag.
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk  input  1  global clock, all logic rising-edge.
- rst  input  1  synchronous, active-low reset.
- s_tdata  input  TDATA_WIDTH  slave data bead.
- s_tlast  input  1  last bead of packet.
- s_tstrb  input  TDATA_WIDTH/8  byte qualifiers.
- s_tuser  input  TUSER_WIDTH  sideband; [0]=error.
- s_tvalid  input  1  upstream data valid.
- s_tready  output  1  block accepts bead.
- m_tdata  output  TDATA_WIDTH  payload bead.
- m_tlast  output  1  last payload bead.
- m_tstrb  output  TDATA_WIDTH/8  payload byte qualifiers.
- m_tuser  output  TUSER_WIDTH  payload sideband.
- m_tvalid  output  1  payload valid.
- m_tready  input  1  downstream ready.
- hdr_dst  output  48  header tdata[47:0].
- hdr_src  output  48  header tdata[95:48].
- hdr_type  output  16  header tdata[111:96].
- hdr_len  output  16  header tdata[127:112].
- hdr_no_pay  output  1  header beat carried tlast (packet has no payload).
- hdr_valid  output  1  header fields valid.
- hdr_ready  input  1  header consumer ready.
- pkt_cnt  output  CNT_WIDTH  packets fully forwarded.
- drop_cnt  output  CNT_WIDTH  packets dropped.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to S_HDR.
  - m_tvalid, hdr_valid, pkt_cnt and drop_cnt clear to 0.
  - m_tdata/m_tlast/m_tstrb/m_tuser and all hdr_* outputs clear to 0.
  - s_tready reads 0 while rst=0.
  - Reset mid-packet abandons the packet; the first post-reset bead is treated as a header.
- Transfer: a transfer occurs on any edge with tvalid&tready. Outputs are registered.
- Registered output rule: m_tvalid/m_t* and hdr_valid/hdr_* hold stable while valid=1 and ready=0.
- s_tready by state (combinational):
  - S_HDR: !hdr_valid | hdr_ready.
  - S_PAY: !m_tvalid | m_tready.
  - S_DROP: 1.
- S_HDR, header bead accepted with s_tuser[0]=1:
  - No header is emitted and drop_cnt increments by 1.
  - tlast=0: go to S_DROP.
  - tlast=1: stay in S_HDR.
- S_HDR, header bead accepted with s_tuser[0]=0:
  - Fields are latched and hdr_valid=1 on the next cycle (latency 1).
  - hdr_no_pay is set to s_tlast.
  - tlast=1: pkt_cnt increments and the state stays S_HDR.
  - tlast=0: go to S_PAY.
- S_PAY: each accepted bead is copied to m_t* with m_tvalid=1 on the next cycle (latency 1).
  - Full throughput: one bead per cycle while m_tready=1.
  - Accepting the tlast bead increments pkt_cnt and returns the state to S_HDR.
- S_DROP: beads are consumed every cycle and nothing is output. The tlast bead returns the state to S_HDR.
- Channel clearing:
  - hdr_valid clears on hdr_valid&hdr_ready unless a new header is accepted on the same edge (back-to-back reload).
  - m_tvalid clears on m_tvalid&m_tready unless a new bead is accepted on the same edge.
- Header and payload channels are independent:
  - Payload may flow while the header is still unconsumed.
  - The next packet's header bead stalls until the previous header is taken.
- tstrb is passed through unmodified. The header bead's tstrb is ignored; the header is assumed full.
- Counters wrap modulo 2^CNT_WIDTH. A drop and a forward cannot occur on the same edge, since there is one bead per edge.
- s_tvalid=0 in any state: no state change and no counter change.

Test Plan:
- Reset with s_tvalid=1 asserted -> s_tready=0, m_tvalid=0, hdr_valid=0, counters 0. Post-reset first bead is decoded as a header.
- 3-bead packet, header tdata=128'h0010_0800_AABBCCDDEEFF_112233445566, m_tready=hdr_ready=1:
  - hdr_dst=48'h112233445566, hdr_src=48'hAABBCCDDEEFF, hdr_type=16'h0800, hdr_len=16'h0010, hdr_no_pay=0.
  - Beads 2,3 appear on m_t* one cycle after acceptance; m_tlast on bead 3.
  - pkt_cnt=1.
- Header-only packet (tlast on bead 1) -> hdr_no_pay=1, no m_tvalid, pkt_cnt=1, state back to S_HDR.
- Packet of 4 beads with s_tuser[0]=1 on the header -> all 4 accepted with s_tready=1; no hdr_valid, no m_tvalid; drop_cnt=1, pkt_cnt unchanged.
- m_tready held 0 for 5 cycles mid-payload:
  - s_tready=0 after one buffered bead.
  - m_t* stable throughout.
  - On release, beads resume in order with none lost or duplicated.
- Two back-to-back packets, hdr_ready=0 until cycle 10:
  - Second header bead stalls (s_tready=0) until the first header is consumed.
  - Second header then appears on the cycle after.
  - pkt_cnt=2 at end.
